// File: rtl/can_bit_destuffer_if.sv
// -----------------------------------------------------------------------------
// can_bit_destuffer_if
// Bit-stream bundle between the sample-point logic and frame decoder (master)
// and the CAN bit de-stuffer (slave).
//   sample_en : one-clk strobe at the bus sample point
//   rx        : sampled bus bit (0 = dominant)
//   stuff_en  : high while inside the stuffed region (SOF..CRC)
//   bit_out   : de-stuffed bit
//   bit_valid : one-clk strobe qualifying bit_out
//   stuff_err : stuff-rule violation indication
//   stuff_cnt : stuff bits removed since the last stuff_en rise (wraps)
//   run_len   : current equal-bit run length (observability)
// -----------------------------------------------------------------------------
interface can_bit_destuffer_if #(
  parameter int CNT_W = 8
);
  logic             sample_en;
  logic             rx;
  logic             stuff_en;
  logic             bit_out;
  logic             bit_valid;
  logic             stuff_err;
  logic [CNT_W-1:0] stuff_cnt;
  logic [3:0]       run_len;

  modport master (
    output sample_en, rx, stuff_en,
    input  bit_out, bit_valid, stuff_err, stuff_cnt, run_len
  );

  modport slave (
    input  sample_en, rx, stuff_en,
    output bit_out, bit_valid, stuff_err, stuff_cnt, run_len
  );
endinterface

// File: rtl/can_bit_destuffer.sv
// -----------------------------------------------------------------------------
// can_bit_destuffer
// Removes CAN stuff bits inside the stuffed region, checks the stuff rule and
// passes bits straight through outside it. Counts removed stuff bits.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   io_bus : can_bit_destuffer_if.slave (sample_en/rx/stuff_en in,
//            bit_out/bit_valid/stuff_err/stuff_cnt/run_len out)
//
// Parameters:
//   STUFF_LEN : equal bits after which a complementary stuff bit is due (2..15)
//   CNT_W     : width of stuff_cnt
//
// Build option:
//   STUFF_ERR_STICKY_EN : when defined, stuff_err latches until reset or the
//                         next stuffed-region start; otherwise it is a 1-clk
//                         pulse on entry to the error state.
// -----------------------------------------------------------------------------
module can_bit_destuffer #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  can_bit_destuffer_if.slave  io_bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_EXPECT = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  localparam logic [3:0] LP_STUFF_LEN = 4'(STUFF_LEN);

  state_t           r_state;
  logic             r_prev;
  logic [3:0]       r_run_len;
  logic [CNT_W-1:0] r_stuff_cnt;
  logic             r_bit_out;
  logic             r_bit_valid;
  logic             r_stuff_err;

  state_t           w_state_next;
  logic             w_prev_next;
  logic [3:0]       w_run_len_next;
  logic [CNT_W-1:0] w_stuff_cnt_next;
  logic             w_bit_out_next;
  logic             w_bit_valid_next;
  logic             w_stuff_err_next;

  logic             w_same;
  logic [3:0]       w_run_step;

  assign w_same     = (io_bus.rx == r_prev);
  // Run length after accepting rx as a data bit while in RUN.
  assign w_run_step = w_same ? (r_run_len + 4'd1) : 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_prev      <= 1'b1;
      r_run_len   <= 4'd0;
      r_stuff_cnt <= '0;
      r_bit_out   <= 1'b1;
      r_bit_valid <= 1'b0;
      r_stuff_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_prev      <= w_prev_next;
      r_run_len   <= w_run_len_next;
      r_stuff_cnt <= w_stuff_cnt_next;
      r_bit_out   <= w_bit_out_next;
      r_bit_valid <= w_bit_valid_next;
      r_stuff_err <= w_stuff_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_prev_next      = r_prev;
    w_run_len_next   = r_run_len;
    w_stuff_cnt_next = r_stuff_cnt;
    w_bit_out_next   = r_bit_out;
    w_bit_valid_next = 1'b0;
`ifdef STUFF_ERR_STICKY_EN
    w_stuff_err_next = r_stuff_err;
`else
    w_stuff_err_next = 1'b0;
`endif

    if (io_bus.sample_en) begin
      if (!io_bus.stuff_en) begin
        // Outside the stuffed region every state, including ERROR, behaves
        // as plain pass-through and settles in IDLE.
        w_bit_out_next   = io_bus.rx;
        w_bit_valid_next = 1'b1;
        w_state_next     = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            // stuff_en rise: new frame, run and counter restart.
            w_prev_next      = io_bus.rx;
            w_run_len_next   = 4'd1;
            w_stuff_cnt_next = '0;
            w_bit_out_next   = io_bus.rx;
            w_bit_valid_next = 1'b1;
            w_stuff_err_next = 1'b0;
            w_state_next     = S_RUN;
          end
          S_RUN: begin
            w_prev_next      = io_bus.rx;
            w_run_len_next   = w_run_step;
            w_bit_out_next   = io_bus.rx;
            w_bit_valid_next = 1'b1;
            if (w_run_step == LP_STUFF_LEN) begin
              w_state_next = S_EXPECT;
            end
          end
          S_EXPECT: begin
            if (!w_same) begin
              // Stuff bit: dropped, but it starts the next run.
              w_prev_next      = io_bus.rx;
              w_run_len_next   = 4'd1;
              w_stuff_cnt_next = r_stuff_cnt + 1'b1;
              w_state_next     = S_RUN;
            end else begin
              w_stuff_err_next = 1'b1;
              w_state_next     = S_ERROR;
            end
          end
          default: begin
            // S_ERROR: strobes ignored while the region stays open.
          end
        endcase
      end
    end
  end

  assign io_bus.bit_out   = r_bit_out;
  assign io_bus.bit_valid = r_bit_valid;
  assign io_bus.stuff_err = r_stuff_err;
  assign io_bus.stuff_cnt = r_stuff_cnt;
  assign io_bus.run_len   = r_run_len;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// -----------------------------------------------------------------------------
// tb_can_bit_destuffer
// Directed self-checking bench for can_bit_destuffer (STUFF_LEN=5, CNT_W=8).
// -----------------------------------------------------------------------------
module tb_can_bit_destuffer;

`ifdef STUFF_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  logic b;

  can_bit_destuffer_if #(.CNT_W(8)) bus ();

  can_bit_destuffer #(
    .STUFF_LEN (5),
    .CNT_W     (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic eb,
                           input logic ee, input logic [7:0] ec, input logic [3:0] er);
    chk({tag, ".valid"}, 32'(bus.bit_valid), 32'(ev));
    chk({tag, ".bit"},   32'(bus.bit_out),   32'(eb));
    chk({tag, ".err"},   32'(bus.stuff_err), 32'(ee));
    chk({tag, ".cnt"},   32'(bus.stuff_cnt), 32'(ec));
    chk({tag, ".run"},   32'(bus.run_len),   32'(er));
  endtask

  task automatic strobe(input logic rx, input logic sen);
    bus.rx        = rx;
    bus.stuff_en  = sen;
    bus.sample_en = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_en = 1'b0;
  endtask

  task automatic step(input string tag, input logic rx, input logic sen,
                      input logic ev, input logic eb, input logic ee,
                      input logic [7:0] ec, input logic [3:0] er);
    strobe(rx, sen);
    $display("step %s rx=%0b stuff_en=%0b -> valid=%0b bit=%0b err=%0b cnt=%0d run=%0d",
             tag, rx, sen, bus.bit_valid, bus.bit_out, bus.stuff_err, bus.stuff_cnt, bus.run_len);
    check_all(tag, ev, eb, ee, ec, er);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.sample_en = 1'b0;
    bus.rx        = 1'b1;
    bus.stuff_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b1, 1'b0, 8'd0, 4'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Pass-through outside the stuffed region, back-to-back strobes.
    step("pt0", 1, 0, 1, 1, 0, 0, 0);
    step("pt1", 0, 0, 1, 0, 0, 0, 0);
    step("pt2", 1, 0, 1, 1, 0, 0, 0);
    step("pt3", 1, 0, 1, 1, 0, 0, 0);
    step("pt4", 1, 0, 1, 1, 0, 0, 0);
    step("pt5", 1, 0, 1, 1, 0, 0, 0);
    step("pt6", 1, 0, 1, 1, 0, 0, 0);
    step("pt7", 1, 0, 1, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("idle cycle -> valid=%0b", bus.bit_valid);
    check_all("pt_idle", 0, 1, 0, 0, 0);

    // Stuff removal: 00000 [1] 0
    step("sr0", 0, 1, 1, 0, 0, 0, 1);
    step("sr1", 0, 1, 1, 0, 0, 0, 2);
    step("sr2", 0, 1, 1, 0, 0, 0, 3);
    step("sr3", 0, 1, 1, 0, 0, 0, 4);
    step("sr4", 0, 1, 1, 0, 0, 0, 5);
    step("sr_stuff", 1, 1, 0, 0, 0, 1, 1);
    step("sr5", 0, 1, 1, 0, 0, 1, 1);
    step("sr_end", 1, 0, 1, 1, 0, 1, 1);

    // Stuff error: six equal bits, then ignored strobe, then region close.
    step("se0", 1, 1, 1, 1, 0, 0, 1);
    step("se1", 1, 1, 1, 1, 0, 0, 2);
    step("se2", 1, 1, 1, 1, 0, 0, 3);
    step("se3", 1, 1, 1, 1, 0, 0, 4);
    step("se4", 1, 1, 1, 1, 0, 0, 5);
    step("se_err", 1, 1, 0, 1, 1, 0, 5);
    step("se_ign", 0, 1, 0, 1, STICKY, 0, 5);
    step("se_exit", 0, 0, 1, 0, STICKY, 0, 5);

    // Chained stuff: 00000 [1] 1111 [0]
    step("ch0", 0, 1, 1, 0, 0, 0, 1);
    step("ch1", 0, 1, 1, 0, 0, 0, 2);
    step("ch2", 0, 1, 1, 0, 0, 0, 3);
    step("ch3", 0, 1, 1, 0, 0, 0, 4);
    step("ch4", 0, 1, 1, 0, 0, 0, 5);
    step("ch_s1", 1, 1, 0, 0, 0, 1, 1);
    step("ch5", 1, 1, 1, 1, 0, 1, 2);
    step("ch6", 1, 1, 1, 1, 0, 1, 3);
    step("ch7", 1, 1, 1, 1, 0, 1, 4);
    step("ch8", 1, 1, 1, 1, 0, 1, 5);
    step("ch_s2", 0, 1, 0, 1, 0, 2, 1);

    // stuff_en falls while in EXPECT with a same-value bit.
    step("ex0", 0, 1, 1, 0, 0, 2, 2);
    step("ex1", 0, 1, 1, 0, 0, 2, 3);
    step("ex2", 0, 1, 1, 0, 0, 2, 4);
    step("ex3", 0, 1, 1, 0, 0, 2, 5);
    step("ex_fall", 0, 0, 1, 0, 0, 2, 5);
    // Next stuffed bit must restart the frame (count cleared) if in IDLE.
    step("ex_idle", 1, 1, 1, 1, 0, 0, 1);

    // Asynchronous reset in RUN with run_len=3.
    step("rr1", 1, 1, 1, 1, 0, 0, 2);
    step("rr2", 1, 1, 1, 1, 0, 0, 3);
    #2;
    reset = 1'b1;
    #1;
    $display("async reset in RUN -> bit=%0b run=%0d", bus.bit_out, bus.run_len);
    check_all("rst_run", 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_rst", 0, 0, 1, 0, 0, 0, 0);

    // Error, then async reset clears a (possibly latched) stuff_err.
    step("e2_0", 1, 1, 1, 1, 0, 0, 1);
    step("e2_1", 1, 1, 1, 1, 0, 0, 2);
    step("e2_2", 1, 1, 1, 1, 0, 0, 3);
    step("e2_3", 1, 1, 1, 1, 0, 0, 4);
    step("e2_4", 1, 1, 1, 1, 0, 0, 5);
    step("e2_err", 1, 1, 0, 1, 1, 0, 5);
    @(posedge clk);
    #1;
    check_all("e2_hold", 0, 1, STICKY, 0, 5);
    #2;
    reset = 1'b1;
    #1;
    $display("async reset in ERROR -> err=%0b", bus.stuff_err);
    check_all("rst_err", 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // stuff_cnt wrap: 256 chained stuff bits.
    strobe(0, 1);
    b = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) strobe(b, 1);
      strobe(~b, 1);
      b = ~b;
      if (i == 254) begin
        $display("wrap at 255 stuff bits -> cnt=%0d", bus.stuff_cnt);
        chk("wrap255.cnt", 32'(bus.stuff_cnt), 32'd255);
      end
    end
    $display("wrap at 256 stuff bits -> cnt=%0d run=%0d", bus.stuff_cnt, bus.run_len);
    check_all("wrap256", 0, ~b, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
